// File: rtl/ghash_mult_scheduler.sv
// ghash_mult_scheduler
//   Two-channel GHASH sequencer in front of one shared, pipelined GF(2^128)
//   multiplier. Each channel accumulates Y_i = (Y_{i-1} ^ X_i) * H. Blocks are
//   granted round-robin, one product per channel in flight at a time. A tag
//   pipeline matched to the multiplier latency routes each product back to
//   its channel's accumulator.
//
// Ports
//   i_clock, i_reset            clock, asynchronous active-high reset
//   i_hkey, i_hkey_load         hash subkey H and its load strobe
//   i_valid_c/i_data_c          block offer on channel c (GCM bit order)
//   i_sop_c/i_eop_c             first / last block of a message
//   o_ready_c                   block accepted when valid & ready
//   o_ghash_c/o_ghash_valid_c   final GHASH and its one-cycle marker
//   o_mult_x/o_mult_y/o_mult_valid  registered multiplier operands
//   i_mult_z                    product, MULT_LAT cycles after o_mult_valid
module ghash_mult_scheduler #(
  parameter int NB_DATA  = 128,
  parameter int MULT_LAT = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_hkey,
  input  logic               i_hkey_load,
  input  logic               i_valid_0,
  input  logic [NB_DATA-1:0] i_data_0,
  input  logic               i_sop_0,
  input  logic               i_eop_0,
  input  logic               i_valid_1,
  input  logic [NB_DATA-1:0] i_data_1,
  input  logic               i_sop_1,
  input  logic               i_eop_1,
  output logic               o_ready_0,
  output logic               o_ready_1,
  output logic [NB_DATA-1:0] o_ghash_0,
  output logic [NB_DATA-1:0] o_ghash_1,
  output logic               o_ghash_valid_0,
  output logic               o_ghash_valid_1,
  output logic [NB_DATA-1:0] o_mult_x,
  output logic [NB_DATA-1:0] o_mult_y,
  output logic               o_mult_valid,
  input  logic [NB_DATA-1:0] i_mult_z
);

  if (NB_DATA != 128) begin : g_bad_nb_data
    $error("ghash_mult_scheduler: NB_DATA must be 128");
  end
  if (MULT_LAT < 1 || MULT_LAT > 4) begin : g_bad_mult_lat
    $error("ghash_mult_scheduler: MULT_LAT must be within 1..4");
  end

  logic [NB_DATA-1:0]  h_reg_q, h_reg_d;
  logic [NB_DATA-1:0]  acc_0_q, acc_0_d, acc_1_q, acc_1_d;
  logic                busy_0_q, busy_0_d, busy_1_q, busy_1_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic [NB_DATA-1:0]  mult_x_q, mult_x_d, mult_y_q, mult_y_d;
  logic                mult_valid_q, mult_valid_d;
  logic                tag_chan_q, tag_chan_d, tag_eop_q, tag_eop_d;
  logic [MULT_LAT-1:0] pipe_v_q, pipe_v_d, pipe_c_q, pipe_c_d, pipe_e_q, pipe_e_d;
  logic [NB_DATA-1:0]  ghash_0_q, ghash_0_d, ghash_1_q, ghash_1_d;
  logic                ghash_valid_0_q, ghash_valid_0_d;
  logic                ghash_valid_1_q, ghash_valid_1_d;

  logic elig_0, elig_1;
  logic wb_v, wb_c, wb_e;

  // A key load blocks issue so every product uses one well-defined H.
  assign elig_0    = i_valid_0 & ~busy_0_q & ~i_hkey_load;
  assign elig_1    = i_valid_1 & ~busy_1_q & ~i_hkey_load;
  assign o_ready_0 = elig_0 & (~rr_ptr_q | ~elig_1);
  assign o_ready_1 = elig_1 & ( rr_ptr_q | ~elig_0);

  // Tag leaving the last stage lines up with i_mult_z.
  assign wb_v = pipe_v_q[MULT_LAT-1];
  assign wb_c = pipe_c_q[MULT_LAT-1];
  assign wb_e = pipe_e_q[MULT_LAT-1];

  always_comb begin
    h_reg_d         = i_hkey_load ? i_hkey : h_reg_q;
    acc_0_d         = acc_0_q;
    acc_1_d         = acc_1_q;
    busy_0_d        = busy_0_q;
    busy_1_d        = busy_1_q;
    rr_ptr_d        = rr_ptr_q;
    mult_x_d        = mult_x_q;
    mult_y_d        = mult_y_q;
    mult_valid_d    = 1'b0;
    tag_chan_d      = tag_chan_q;
    tag_eop_d       = tag_eop_q;
    ghash_0_d       = ghash_0_q;
    ghash_1_d       = ghash_1_q;
    ghash_valid_0_d = 1'b0;
    ghash_valid_1_d = 1'b0;

    if (o_ready_0) begin
      mult_x_d     = (i_sop_0 ? '0 : acc_0_q) ^ i_data_0;
      mult_y_d     = h_reg_q;
      mult_valid_d = 1'b1;
      tag_chan_d   = 1'b0;
      tag_eop_d    = i_eop_0;
      busy_0_d     = 1'b1;
      rr_ptr_d     = 1'b1;
    end else if (o_ready_1) begin
      mult_x_d     = (i_sop_1 ? '0 : acc_1_q) ^ i_data_1;
      mult_y_d     = h_reg_q;
      mult_valid_d = 1'b1;
      tag_chan_d   = 1'b1;
      tag_eop_d    = i_eop_1;
      busy_1_d     = 1'b1;
      rr_ptr_d     = 1'b0;
    end

    pipe_v_d    = pipe_v_q;
    pipe_c_d    = pipe_c_q;
    pipe_e_d    = pipe_e_q;
    pipe_v_d[0] = mult_valid_q;
    pipe_c_d[0] = tag_chan_q;
    pipe_e_d[0] = tag_eop_q;
    for (int i = 1; i < MULT_LAT; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_c_d[i] = pipe_c_q[i-1];
      pipe_e_d[i] = pipe_e_q[i-1];
    end

    // The owning channel is busy, so this never collides with an issue on it.
    if (wb_v) begin
      if (!wb_c) begin
        acc_0_d  = i_mult_z;
        busy_0_d = 1'b0;
        if (wb_e) begin
          ghash_0_d       = i_mult_z;
          ghash_valid_0_d = 1'b1;
        end
      end else begin
        acc_1_d  = i_mult_z;
        busy_1_d = 1'b0;
        if (wb_e) begin
          ghash_1_d       = i_mult_z;
          ghash_valid_1_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      h_reg_q         <= '0;
      acc_0_q         <= '0;
      acc_1_q         <= '0;
      busy_0_q        <= 1'b0;
      busy_1_q        <= 1'b0;
      rr_ptr_q        <= 1'b0;
      mult_x_q        <= '0;
      mult_y_q        <= '0;
      mult_valid_q    <= 1'b0;
      tag_chan_q      <= 1'b0;
      tag_eop_q       <= 1'b0;
      pipe_v_q        <= '0;
      pipe_c_q        <= '0;
      pipe_e_q        <= '0;
      ghash_0_q       <= '0;
      ghash_1_q       <= '0;
      ghash_valid_0_q <= 1'b0;
      ghash_valid_1_q <= 1'b0;
    end else begin
      h_reg_q         <= h_reg_d;
      acc_0_q         <= acc_0_d;
      acc_1_q         <= acc_1_d;
      busy_0_q        <= busy_0_d;
      busy_1_q        <= busy_1_d;
      rr_ptr_q        <= rr_ptr_d;
      mult_x_q        <= mult_x_d;
      mult_y_q        <= mult_y_d;
      mult_valid_q    <= mult_valid_d;
      tag_chan_q      <= tag_chan_d;
      tag_eop_q       <= tag_eop_d;
      pipe_v_q        <= pipe_v_d;
      pipe_c_q        <= pipe_c_d;
      pipe_e_q        <= pipe_e_d;
      ghash_0_q       <= ghash_0_d;
      ghash_1_q       <= ghash_1_d;
      ghash_valid_0_q <= ghash_valid_0_d;
      ghash_valid_1_q <= ghash_valid_1_d;
    end
  end

  assign o_mult_x        = mult_x_q;
  assign o_mult_y        = mult_y_q;
  assign o_mult_valid    = mult_valid_q;
  assign o_ghash_0       = ghash_0_q;
  assign o_ghash_1       = ghash_1_q;
  assign o_ghash_valid_0 = ghash_valid_0_q;
  assign o_ghash_valid_1 = ghash_valid_1_q;

endmodule

// File: tb/tb_ghash_mult_scheduler.sv
module tb_ghash_mult_scheduler;
  localparam int NB_DATA  = 128;
  localparam int MULT_LAT = 2;

  localparam logic [127:0] UNITY = {1'b1, 127'b0};
  localparam logic [127:0] HK    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] H2    = 128'hb83b533708bf535d0aa6e52980d53b78;

  logic               i_clock = 1'b0;
  logic               i_reset = 1'b1;
  logic [127:0]       i_hkey = '0;
  logic               i_hkey_load = 1'b0;
  logic               i_valid_0 = 1'b0, i_sop_0 = 1'b0, i_eop_0 = 1'b0;
  logic               i_valid_1 = 1'b0, i_sop_1 = 1'b0, i_eop_1 = 1'b0;
  logic [127:0]       i_data_0 = '0, i_data_1 = '0;
  logic               o_ready_0, o_ready_1;
  logic [127:0]       o_ghash_0, o_ghash_1;
  logic               o_ghash_valid_0, o_ghash_valid_1;
  logic [127:0]       o_mult_x, o_mult_y;
  logic               o_mult_valid;
  logic [127:0]       i_mult_z;

  int n_total = 0;
  int n_bad   = 0;

  ghash_mult_scheduler #(.NB_DATA(NB_DATA), .MULT_LAT(MULT_LAT)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_hkey(i_hkey), .i_hkey_load(i_hkey_load),
    .i_valid_0(i_valid_0), .i_data_0(i_data_0), .i_sop_0(i_sop_0), .i_eop_0(i_eop_0),
    .i_valid_1(i_valid_1), .i_data_1(i_data_1), .i_sop_1(i_sop_1), .i_eop_1(i_eop_1),
    .o_ready_0(o_ready_0), .o_ready_1(o_ready_1),
    .o_ghash_0(o_ghash_0), .o_ghash_1(o_ghash_1),
    .o_ghash_valid_0(o_ghash_valid_0), .o_ghash_valid_1(o_ghash_valid_1),
    .o_mult_x(o_mult_x), .o_mult_y(o_mult_y), .o_mult_valid(o_mult_valid),
    .i_mult_z(i_mult_z)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [127:0] gfmul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  // External multiplier model: MULT_LAT-stage pipeline.
  logic [127:0] z_pipe [MULT_LAT];
  always @(posedge i_clock) begin
    z_pipe[0] <= o_mult_valid ? gfmul(o_mult_x, o_mult_y) : '0;
    for (int i = 1; i < MULT_LAT; i++) z_pipe[i] <= z_pipe[i-1];
  end
  assign i_mult_z = z_pipe[MULT_LAT-1];

  // Cycle counter and observation monitor (samples 2 time units after negedge).
  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  int n_mv = 0, n_gv0 = 0, n_gv1 = 0, gv0_cyc = -1, gv1_cyc = -1;
  logic [127:0] gh0 = '0, gh1 = '0;
  int hs_q[$];
  always @(negedge i_clock) begin
    #2;
    if (i_valid_0 && o_ready_0) hs_q.push_back(0);
    if (i_valid_1 && o_ready_1) hs_q.push_back(1);
    if (o_mult_valid) n_mv++;
    if (o_ghash_valid_0) begin n_gv0++; gh0 = o_ghash_0; gv0_cyc = cyc; end
    if (o_ghash_valid_1) begin n_gv1++; gh1 = o_ghash_1; gv1_cyc = cyc; end
  end

  // Caller is at a negedge; returns at a negedge one cycle after the handshake.
  task automatic send_block(input int ch, input logic [127:0] d, input bit sop,
                            input bit eop, output int hs_cyc);
    bit got;
    got = 0;
    hs_cyc = -1;
    if (ch == 0) begin i_valid_0 = 1; i_data_0 = d; i_sop_0 = sop; i_eop_0 = eop; end
    else         begin i_valid_1 = 1; i_data_1 = d; i_sop_1 = sop; i_eop_1 = eop; end
    for (int k = 0; k < 40 && !got; k++) begin
      #1;
      if ((ch == 0) ? o_ready_0 : o_ready_1) begin got = 1; hs_cyc = cyc; end
      @(negedge i_clock);
    end
    if (ch == 0) i_valid_0 = 0; else i_valid_1 = 0;
    n_total++;
    if (!got) begin n_bad++; $display("FAIL handshake_timeout ch=%0d got=0 expected=1", ch); end
  endtask

  task automatic load_key(input logic [127:0] h);
    i_hkey = h;
    i_hkey_load = 1;
    @(negedge i_clock);
    i_hkey_load = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clock);
    #1;
    n_total++; if (o_mult_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mult_valid got=%b exp=0", o_mult_valid); end
    n_total++; if (o_mult_x !== '0) begin n_bad++; $display("FAIL rst_mult_x got=%h exp=0", o_mult_x); end
    n_total++; if (o_mult_y !== '0) begin n_bad++; $display("FAIL rst_mult_y got=%h exp=0", o_mult_y); end
    n_total++; if ({o_ghash_0, o_ghash_1} !== '0) begin n_bad++; $display("FAIL rst_ghash got=%h_%h exp=0", o_ghash_0, o_ghash_1); end
    n_total++; if ({o_ghash_valid_0, o_ghash_valid_1} !== 2'b00) begin n_bad++; $display("FAIL rst_ghash_valid got=%b%b exp=00", o_ghash_valid_0, o_ghash_valid_1); end
    @(negedge i_clock);
    i_reset = 0;
    @(negedge i_clock);
    // Key load cycle must block a ready offer.
    i_valid_0 = 1; i_data_0 = 128'h5; i_sop_0 = 1; i_eop_0 = 1;
    i_hkey = UNITY; i_hkey_load = 1;
    #1;
    n_total++; if (o_ready_0 !== 1'b0) begin n_bad++; $display("FAIL rst_ready_during_load got=%b exp=0", o_ready_0); end
    @(negedge i_clock);
    i_valid_0 = 0; i_hkey_load = 0;
    #1;
    n_total++; if (o_mult_valid !== 1'b0) begin n_bad++; $display("FAIL rst_no_issue_in_load got=%b exp=0", o_mult_valid); end
    @(negedge i_clock);
  endtask

  task automatic test_single_block();
    logic [127:0] d;
    int t, b_gv, b_mv;
    d = 128'h0123456789abcdef0011223344556677;
    load_key(UNITY);
    b_gv = n_gv0; b_mv = n_mv;
    send_block(0, d, 1, 1, t);
    repeat (MULT_LAT + 4) @(negedge i_clock);
    n_total++; if (n_gv0 - b_gv !== 1) begin n_bad++; $display("FAIL single_pulses got=%0d exp=1", n_gv0 - b_gv); end
    n_total++; if (gh0 !== d) begin n_bad++; $display("FAIL single_ghash got=%h exp=%h", gh0, d); end
    n_total++; if (gv0_cyc !== t + 2 + MULT_LAT) begin n_bad++; $display("FAIL single_latency got=%0d exp=%0d", gv0_cyc, t + 2 + MULT_LAT); end
    n_total++; if (n_mv - b_mv !== 1) begin n_bad++; $display("FAIL single_mult_valid_cycles got=%0d exp=1", n_mv - b_mv); end
  endtask

  task automatic test_multi_block();
    int t0, t1, t2, b_gv;
    b_gv = n_gv1;
    send_block(1, {16{8'h11}}, 1, 0, t0);
    send_block(1, {16{8'h22}}, 0, 0, t1);
    send_block(1, {16{8'h44}}, 0, 1, t2);
    repeat (MULT_LAT + 4) @(negedge i_clock);
    n_total++; if (t1 - t0 !== MULT_LAT + 2) begin n_bad++; $display("FAIL multi_interval1 got=%0d exp=%0d", t1 - t0, MULT_LAT + 2); end
    n_total++; if (t2 - t1 !== MULT_LAT + 2) begin n_bad++; $display("FAIL multi_interval2 got=%0d exp=%0d", t2 - t1, MULT_LAT + 2); end
    n_total++; if (n_gv1 - b_gv !== 1) begin n_bad++; $display("FAIL multi_pulses got=%0d exp=1", n_gv1 - b_gv); end
    n_total++; if (gh1 !== {16{8'h77}}) begin n_bad++; $display("FAIL multi_ghash got=%h exp=%h", gh1, {16{8'h77}}); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] b0 [4];
    logic [127:0] b1 [4];
    logic [127:0] y0, y1;
    for (int i = 0; i < 4; i++) begin
      b0[i] = {32'h0388dace, 32'h60b6a392, 32'hf328c2b9, 32'h71b2fe78} ^ 128'(i * 32'h01010101);
      b1[i] = {32'h42831ec2, 32'h21777424, 32'h4b7221b7, 32'h84d0d49c} ^ {96'h0, 32'(i + 7)};
    end
    y0 = '0; y1 = '0;
    for (int i = 0; i < 4; i++) begin
      y0 = gfmul(y0 ^ b0[i], HK);
      y1 = gfmul(y1 ^ b1[i], HK);
    end
    i_reset = 1;
    @(negedge i_clock);
    i_reset = 0;
    @(negedge i_clock);
    load_key(HK);
    hs_q.delete();
    fork
      begin
        int t;
        for (int i = 0; i < 4; i++) send_block(0, b0[i], i == 0, i == 3, t);
      end
      begin
        int t;
        for (int i = 0; i < 4; i++) send_block(1, b1[i], i == 0, i == 3, t);
      end
    join
    repeat (MULT_LAT + 4) @(negedge i_clock);
    n_total++; if (hs_q.size() !== 8) begin n_bad++; $display("FAIL b2b_grant_count got=%0d exp=8", hs_q.size()); end
    for (int i = 0; i < 8 && i < hs_q.size(); i++) begin
      n_total++;
      if (hs_q[i] !== i % 2) begin n_bad++; $display("FAIL b2b_grant_order idx=%0d got=%0d exp=%0d", i, hs_q[i], i % 2); end
    end
    n_total++; if (gh0 !== y0) begin n_bad++; $display("FAIL b2b_ghash0 got=%h exp=%h", gh0, y0); end
    n_total++; if (gh1 !== y1) begin n_bad++; $display("FAIL b2b_ghash1 got=%h exp=%h", gh1, y1); end
  endtask

  task automatic test_hkey_reload();
    logic [127:0] d, e;
    d = 128'hfeedfacedeadbeefcafebabe12345678;
    e = 128'h00000000000000010000000000000002;
    i_valid_0 = 1; i_data_0 = d; i_sop_0 = 1; i_eop_0 = 1;
    #1;
    n_total++; if (o_ready_0 !== 1'b1) begin n_bad++; $display("FAIL hkey_issue_ready got=%b exp=1", o_ready_0); end
    @(negedge i_clock);
    i_valid_0 = 0;
    i_hkey = H2; i_hkey_load = 1;
    i_valid_1 = 1; i_data_1 = e; i_sop_1 = 1; i_eop_1 = 1;
    #1;
    n_total++; if (o_ready_1 !== 1'b0) begin n_bad++; $display("FAIL hkey_no_grant_in_load got=%b exp=0", o_ready_1); end
    n_total++; if (o_mult_y !== HK) begin n_bad++; $display("FAIL hkey_old_h_issued got=%h exp=%h", o_mult_y, HK); end
    @(negedge i_clock);
    i_hkey_load = 0;
    #1;
    n_total++; if (o_ready_1 !== 1'b1) begin n_bad++; $display("FAIL hkey_grant_after_load got=%b exp=1", o_ready_1); end
    @(negedge i_clock);
    i_valid_1 = 0;
    #1;
    n_total++; if (o_mult_y !== H2) begin n_bad++; $display("FAIL hkey_new_h_issued got=%h exp=%h", o_mult_y, H2); end
    repeat (MULT_LAT + 4) @(negedge i_clock);
    n_total++; if (gh0 !== gfmul(d, HK)) begin n_bad++; $display("FAIL hkey_ghash0 got=%h exp=%h", gh0, gfmul(d, HK)); end
    n_total++; if (gh1 !== gfmul(e, H2)) begin n_bad++; $display("FAIL hkey_ghash1 got=%h exp=%h", gh1, gfmul(e, H2)); end
  endtask

  task automatic test_reset_inflight();
    int b0, b1, t;
    logic [127:0] f;
    f = 128'h9abcdef00fedcba98765432112345678;
    i_valid_0 = 1; i_data_0 = 128'h1; i_sop_0 = 1; i_eop_0 = 1;
    @(negedge i_clock);
    i_valid_0 = 0;
    i_valid_1 = 1; i_data_1 = 128'h2; i_sop_1 = 1; i_eop_1 = 1;
    @(negedge i_clock);
    i_valid_1 = 0;
    i_reset = 1;
    #1;
    n_total++; if (o_mult_valid !== 1'b0) begin n_bad++; $display("FAIL rstfl_mult_valid got=%b exp=0", o_mult_valid); end
    n_total++; if ({o_mult_x, o_mult_y} !== '0) begin n_bad++; $display("FAIL rstfl_operands got=%h_%h exp=0", o_mult_x, o_mult_y); end
    n_total++; if ({o_ghash_0, o_ghash_1} !== '0) begin n_bad++; $display("FAIL rstfl_ghash got=%h_%h exp=0", o_ghash_0, o_ghash_1); end
    b0 = n_gv0; b1 = n_gv1;
    repeat (2) @(negedge i_clock);
    i_reset = 0;
    repeat (10) @(negedge i_clock);
    n_total++; if (n_gv0 + n_gv1 - b0 - b1 !== 0) begin n_bad++; $display("FAIL rstfl_stale_pulse got=%0d exp=0", n_gv0 + n_gv1 - b0 - b1); end
    load_key(HK);
    b1 = n_gv1;
    send_block(1, f, 1, 1, t);
    repeat (MULT_LAT + 4) @(negedge i_clock);
    n_total++; if (n_gv1 - b1 !== 1) begin n_bad++; $display("FAIL rstfl_new_pulses got=%0d exp=1", n_gv1 - b1); end
    n_total++; if (gh1 !== gfmul(f, HK)) begin n_bad++; $display("FAIL rstfl_new_ghash got=%h exp=%h", gh1, gfmul(f, HK)); end
  endtask

  task automatic test_restart_abandon();
    logic [127:0] a, b;
    int t, bg;
    a = 128'hababababcdcdcdcdefefefef01010101;
    b = 128'h13579bdf2468ace0fdb97531eca86420;
    bg = n_gv0;
    send_block(0, a, 1, 0, t);
    send_block(0, b, 1, 1, t);
    repeat (MULT_LAT + 4) @(negedge i_clock);
    n_total++; if (n_gv0 - bg !== 1) begin n_bad++; $display("FAIL restart_pulses got=%0d exp=1", n_gv0 - bg); end
    n_total++; if (gh0 !== gfmul(b, HK)) begin n_bad++; $display("FAIL restart_ghash got=%h exp=%h", gh0, gfmul(b, HK)); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_multi_block();
    test_back_to_back();
    test_hkey_reload();
    test_reset_inflight();
    test_restart_abandon();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ghash_mult_scheduler.md
# ghash_mult_scheduler

Sequencer and two-channel round-robin arbiter for one shared, pipelined GF(2^128) GCM multiplier. It computes GHASH, Y_i = (Y_{i-1} xor X_i)·H, independently for two block streams. It drives the external multiplier operand ports, tracks in-flight products with a tag pipeline, and writes each product back to the owning channel's accumulator. The block sits between the GCM block formatter and the multiplier instance in the GHASH path.

## Interface

Parameters:

- NB_DATA, 128, block and operand width; any other value is a bad configuration.
- MULT_LAT, 2, multiplier latency in cycles from o_mult_valid to valid i_mult_z; legal range 1..4.

Ports:

- i_clock, input, 1, single clock.
- i_reset, input, 1, asynchronous, active-high reset.
- i_hkey, input, NB_DATA, hash subkey H.
- i_hkey_load, input, 1, capture i_hkey into h_reg.
- i_valid_0 / i_valid_1, input, 1, a block is offered on channel 0 / 1.
- i_data_0 / i_data_1, input, NB_DATA, block X_i, GCM bit order (bit NB_DATA-1 is coefficient x^0).
- i_sop_0 / i_sop_1, input, 1, first block of a message.
- i_eop_0 / i_eop_1, input, 1, last block of a message.
- o_ready_0 / o_ready_1, output, 1, block accepted when valid & ready.
- o_ghash_0 / o_ghash_1, output, NB_DATA, final GHASH of the channel.
- o_ghash_valid_0 / o_ghash_valid_1, output, 1, one-cycle pulse marking o_ghash.
- o_mult_x, output, NB_DATA, multiplier operand X, registered.
- o_mult_y, output, NB_DATA, multiplier operand Y (H), registered.
- o_mult_valid, output, 1, operands valid, registered.
- i_mult_z, input, NB_DATA, product, valid exactly MULT_LAT cycles after o_mult_valid.

## Operation

- Per-channel state:
  - busy_c: one product in flight.
  - acc_c: accumulator.
- Eligibility: channel c is eligible when i_valid_c & ~busy_c & ~i_hkey_load.
- Arbitration:
  - rr_ptr (1 bit) selects the preferred channel.
  - o_ready_c = eligible_c & (rr_ptr==c | ~eligible_other).
  - At most one handshake per cycle.
  - After a grant to c, rr_ptr is set to the other channel. With no grant, rr_ptr holds.
  - o_ready depends combinationally on i_valid; upstream must not make i_valid depend on o_ready.
- Issue, on handshake of channel c:
  - o_mult_x <= (i_sop_c ? 0 : acc_c) ^ i_data_c.
  - o_mult_y <= h_reg.
  - o_mult_valid <= 1.
  - busy_c <= 1.
  - Tag {valid, chan=c, eop} enters the tag pipeline.
- Tag pipeline: MULT_LAT stages fed from the registered tag, so the tag is aligned with i_mult_z.
- Writeback, when the tag output is valid for channel c:
  - acc_c <= i_mult_z and busy_c <= 0.
  - If the tag has eop set: o_ghash_c <= i_mult_z and o_ghash_valid_c <= 1 for one cycle.
- Key load:
  - i_hkey_load writes h_reg on the next edge and suppresses issue in that cycle.
  - In-flight products keep the H value that was sent at issue.
- A block with both sop and eop set is a single-block message.
- A sop block arriving while the previous message had no eop restarts the channel; the old accumulation is abandoned without an o_ghash_valid pulse.
- Simultaneous writeback to channel c and handshake on c cannot occur, because c is busy.
- A writeback on one channel and an issue on the other in the same cycle are both serviced.
- Reset:
  - Clears h_reg, acc_0/1, busy_0/1, rr_ptr=0, all tag valids, o_mult_valid, o_mult_x/y, o_ghash_0/1 and o_ghash_valid_0/1 (all outputs 0).
  - Products in flight at reset are discarded; i_mult_z is ignored until a new issue.

## Timing

- Handshake in cycle t:
  - o_mult_valid is high in t+1.
  - i_mult_z is sampled in t+1+MULT_LAT.
  - acc_c is updated and o_ghash_valid_c pulses in t+2+MULT_LAT.
- busy_c is high from t+1 through t+1+MULT_LAT. The earliest next o_ready_c is t+2+MULT_LAT, so the per-channel issue interval is MULT_LAT+2 cycles.
- Both channels active give alternating issues. Multiplier utilisation is at most 2/(MULT_LAT+2).
- o_mult_valid is high for exactly one cycle per accepted block.
- o_ready_c is 0 in any cycle with i_hkey_load=1.

## Test plan

- H=0x80…0 (GF unity) loaded. Channel 0 sends one block sop=eop=1 with D=0x0123456789abcdef0011223344556677. Required: o_ghash_0=D and o_ghash_valid_0 pulse at t+2+MULT_LAT.
- H=0x80…0. Channel 1 sends a 3-block message 0x11…11, 0x22…22, 0x44…44. Required: o_ghash_1=0x77…77; o_ready_1 is low for MULT_LAT+1 cycles after each handshake.
- H=0x66e94bd4ef8a2c3b884cfa59ca342b2e. Both channels offer a valid 4-block message continuously. Required: grants alternate 0,1,0,1…, starting with channel 0 after reset. Both o_ghash values match a software GHASH model.
- Issue on channel 0, then pulse i_hkey_load with a new H in the following cycle. Required: the in-flight product uses the old H; the next issue uses the new H; no grant in the load cycle.
- Assert i_reset with products in flight on both channels. Required: all outputs 0 immediately; no o_ghash_valid pulse after release; the next sop message computes correctly.
- Channel 0: send sop block A without eop, then sop=eop block B. Required: a single o_ghash_0 = B·H and no pulse for the abandoned message.
